// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI types and constants.
// Used by the master and reusable by the slave side.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } spi_state_e;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int BYTE_BITS = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit.
// Reset value is a parameter so idle-high lines can use it too.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic reset_n_in,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: byte-wide SPI mode-0 master, MSB first.
// CS may be held low across bytes for multi-byte transactions.
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int CS_DELAY    = 4
) (
  input  logic                 clk_in,
  input  logic                 reset_n_in,
  input  logic [BYTE_BITS-1:0] data_in,
  input  logic                 data_valid_in,
  input  logic                 hold_cs_in,
  output logic                 ready_out,
  output logic [BYTE_BITS-1:0] data_out,
  output logic                 data_valid_out,
  output logic                 spi_sclk_out,
  output logic                 spi_cs_out,
  output logic                 spi_mosi_out,
  input  logic                 spi_miso_in
);

  localparam int MAXP = max2(HALF_PERIOD, CS_DELAY);
  localparam int CW   = $clog2(MAXP);

  localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] CS_LAST = CW'(CS_DELAY - 1);
  localparam logic [2:0]    LAST_BIT = 3'(BYTE_BITS - 1);

  spi_state_e state, state_d;

  logic [CW-1:0]          phase_cnt, phase_d;
  logic [2:0]             bit_cnt, bit_d;
  logic [BYTE_BITS-1:0]   tx_shift, tx_d;
  // only the 7 earliest bits are stored; bit 0 joins on the fly
  logic [BYTE_BITS-2:0]   rx_shift, rx_d;
  logic                   cs_held, held_d;
  logic                   sclk_d, cs_d;
  logic [BYTE_BITS-1:0]   dout_d;
  logic                   dv_d, ready_d;
  logic                   miso_sync;
  logic                   accept;

  sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_miso_sync (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .d          (spi_miso_in),
    .q          (miso_sync)
  );

  assign spi_mosi_out = tx_shift[BYTE_BITS-1];
  assign accept       = ready_out & data_valid_in;

  always_comb begin
    state_d = state;
    phase_d = phase_cnt;
    bit_d   = bit_cnt;
    tx_d    = tx_shift;
    rx_d    = rx_shift;
    held_d  = cs_held;
    sclk_d  = spi_sclk_out;
    cs_d    = spi_cs_out;
    dout_d  = data_out;
    dv_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          tx_d    = data_in;
          held_d  = hold_cs_in;
          bit_d   = '0;
          phase_d = '0;
          if (cs_held) begin
            state_d = LOW;
          end else begin
            cs_d    = 1'b0;
            state_d = SETUP;
          end
        end else if (cs_held && !data_valid_in && !hold_cs_in) begin
          held_d  = 1'b0;
          phase_d = '0;
          state_d = HOLD;
        end
      end
      SETUP: begin
        if (phase_cnt == CS_LAST) begin
          phase_d = '0;
          state_d = LOW;
        end else begin
          phase_d = phase_cnt + CW'(1);
        end
      end
      LOW: begin
        if (phase_cnt == HP_LAST) begin
          phase_d = '0;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          phase_d = phase_cnt + CW'(1);
        end
      end
      HIGH: begin
        if (phase_cnt == HP_LAST) begin
          phase_d = '0;
          sclk_d  = 1'b0;
          rx_d    = {rx_shift[BYTE_BITS-3:0], miso_sync};
          if (bit_cnt != LAST_BIT) begin
            tx_d    = tx_shift << 1;
            bit_d   = bit_cnt + 3'd1;
            state_d = LOW;
          end else begin
            dout_d  = {rx_shift, miso_sync};
            dv_d    = 1'b1;
            state_d = cs_held ? IDLE : HOLD;
          end
        end else begin
          phase_d = phase_cnt + CW'(1);
        end
      end
      HOLD: begin
        if (phase_cnt == CS_LAST) begin
          phase_d = '0;
          cs_d    = 1'b1;
          state_d = GAP;
        end else begin
          phase_d = phase_cnt + CW'(1);
        end
      end
      GAP: begin
        if (phase_cnt == CS_LAST) begin
          phase_d = '0;
          state_d = IDLE;
        end else begin
          phase_d = phase_cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    // ready only after a full cycle already spent in IDLE
    ready_d = (state == IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state          <= IDLE;
      phase_cnt      <= '0;
      bit_cnt        <= '0;
      tx_shift       <= '0;
      rx_shift       <= '0;
      cs_held        <= 1'b0;
      spi_sclk_out   <= SPI_CPOL;
      spi_cs_out     <= 1'b1;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      ready_out      <= 1'b1;
    end else begin
      state          <= state_d;
      phase_cnt      <= phase_d;
      bit_cnt        <= bit_d;
      tx_shift       <= tx_d;
      rx_shift       <= rx_d;
      cs_held        <= held_d;
      spi_sclk_out   <= sclk_d;
      spi_cs_out     <= cs_d;
      data_out       <= dout_d;
      data_valid_out <= dv_d;
      ready_out      <= ready_d;
    end
  end

endmodule
